nukv_rotation_matrix_assembler: RTL and testbench

NUKV_ROTATION_MATRIX_ASSEMBLER -- requirements
Module: nukv_rotation_matrix_assembler

---
 rtl/nukv_matrix_pkg.sv | 33 +++
 rtl/nukv_rotation_matrix_assembler_if.sv | 27 ++
 rtl/nukv_matrix_bank.sv | 48 ++++
 rtl/nukv_rotation_matrix_assembler.sv | 137 +++++++++++++
 tb/tb_nukv_rotation_matrix_assembler.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/nukv_matrix_pkg.sv
// Shared types and size helpers for the rotation-matrix assembler.
// Default-size constants plus functions so parameterised instances derive the same values.
package nukv_matrix_pkg;

    typedef enum logic [1:0] {
        ST_FIRST = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2
    } fill_state_t;

    localparam int DEF_MEMORY_WIDTH = 512;
    localparam int DEF_ROW_COUNT    = 3;
    localparam int DEF_COL_COUNT    = 3;
    localparam int DEF_COL_WIDTH    = 64;
    localparam int DEF_HEADER_BYTES = 2;

    function automatic int calc_mb(input int rows, input int cols, input int col_width);
        return rows * cols * col_width;
    endfunction

    function automatic int calc_first_bits(input int memory_width, input int header_bytes);
        return memory_width - 8 * header_bytes;
    endfunction

    function automatic int calc_off_w(input int mb, input int memory_width);
        return $clog2(mb + memory_width) + 1;
    endfunction

    localparam int MB         = calc_mb(DEF_ROW_COUNT, DEF_COL_COUNT, DEF_COL_WIDTH);
    localparam int FIRST_BITS = calc_first_bits(DEF_MEMORY_WIDTH, DEF_HEADER_BYTES);
    localparam int OFF_W      = calc_off_w(MB, DEF_MEMORY_WIDTH);

endpackage

// File: rtl/nukv_rotation_matrix_assembler_if.sv
// Value word stream in, assembled matrix stream out, plus the two error pulses.
interface nukv_rotation_matrix_assembler_if
    import nukv_matrix_pkg::*;
#(
    parameter int MEMORY_WIDTH = DEF_MEMORY_WIDTH,
    parameter int MATRIX_BITS  = MB
);
    logic [MEMORY_WIDTH-1:0] value_data;
    logic                    value_valid;
    logic                    value_last;
    logic                    value_ready;
    logic [MATRIX_BITS-1:0]  matrix_data;
    logic                    matrix_valid;
    logic                    matrix_ready;
    logic                    err_short;
    logic                    err_long;

    modport master (
        output value_data, value_valid, value_last, matrix_ready,
        input  value_ready, matrix_data, matrix_valid, err_short, err_long
    );

    modport slave (
        input  value_data, value_valid, value_last, matrix_ready,
        output value_ready, matrix_data, matrix_valid, err_short, err_long
    );
endinterface

// File: rtl/nukv_matrix_bank.sv
// One matrix buffer: writes a word at a bit offset, dropping anything past the matrix end.
module nukv_matrix_bank
    import nukv_matrix_pkg::*;
#(
    parameter int MEMORY_WIDTH = DEF_MEMORY_WIDTH,
    parameter int MATRIX_BITS  = MB,
    parameter int OFFSET_W     = OFF_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [OFFSET_W-1:0]     wr_offset,
    input  logic [MEMORY_WIDTH-1:0] wr_data,
    input  logic                    set_full,
    input  logic                    clr_full,
    output logic [MATRIX_BITS-1:0]  data,
    output logic                    full
);
    localparam int SPAN_W = MATRIX_BITS + MEMORY_WIDTH;

    logic [SPAN_W-1:0]      wide_data;
    logic [SPAN_W-1:0]      wide_mask;
    logic [MATRIX_BITS-1:0] wr_part;
    logic [MATRIX_BITS-1:0] wr_mask;

    assign wide_data = SPAN_W'(wr_data);
    assign wide_mask = SPAN_W'({MEMORY_WIDTH{1'b1}});
    assign wr_part   = MATRIX_BITS'(wide_data << wr_offset);
    assign wr_mask   = MATRIX_BITS'(wide_mask << wr_offset);

    // NOTE: storage is deliberately not reset; the full flag alone decides whether it holds a matrix.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            data <= (data & ~wr_mask) | wr_part;
        end
    end

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full <= 1'b0;
        end else if (set_full) begin
            full <= 1'b1;
        end else if (clr_full) begin
            full <= 1'b0;
        end
    end
endmodule

// File: rtl/nukv_rotation_matrix_assembler.sv
// Strips the value header, packs words into a ping-pong pair of matrix banks and presents them in order.
module nukv_rotation_matrix_assembler
    import nukv_matrix_pkg::*;
#(
    parameter int MEMORY_WIDTH = DEF_MEMORY_WIDTH,
    parameter int ROW_COUNT    = DEF_ROW_COUNT,
    parameter int COL_COUNT    = DEF_COL_COUNT,
    parameter int COL_WIDTH    = DEF_COL_WIDTH,
    parameter int HEADER_BYTES = DEF_HEADER_BYTES
) (
    input logic                           clk,
    input logic                           rst,
    nukv_rotation_matrix_assembler_if.slave bus
);
    localparam int MAT_BITS = calc_mb(ROW_COUNT, COL_COUNT, COL_WIDTH);
    localparam int FIRST_W  = calc_first_bits(MEMORY_WIDTH, HEADER_BYTES);
    localparam int OFFSET_W = calc_off_w(MAT_BITS, MEMORY_WIDTH);

    localparam logic [OFFSET_W-1:0] MAT_END   = OFFSET_W'(MAT_BITS);
    localparam logic [OFFSET_W-1:0] FIRST_END = OFFSET_W'(FIRST_W);
    localparam logic [OFFSET_W-1:0] WORD_W    = OFFSET_W'(MEMORY_WIDTH);
    localparam bit                  FIRST_COMPLETES = (FIRST_W >= MAT_BITS);

    fill_state_t             state, state_n;
    logic [OFFSET_W-1:0]     offset, offset_n, fill_end, wr_offset;
    logic                    fill_sel, pres_sel;
    logic                    drain_err_seen, drain_err_seen_n;
    logic                    err_short_q, err_short_n, err_long_q, err_long_n;
    logic                    value_ready, matrix_valid, accept, handshake;
    logic                    wr_en, wr_first, set_full;
    logic [MEMORY_WIDTH-1:0] wr_data;
    logic [MAT_BITS-1:0]     bank_data [2];
    logic [1:0]              bank_full;

    // Draining words never touch a bank, so they are accepted even with both banks full.
    assign value_ready  = (state == ST_DRAIN) || !(&bank_full);
    assign matrix_valid = bank_full[pres_sel];
    assign accept       = bus.value_valid && value_ready;
    assign handshake    = matrix_valid && bus.matrix_ready;

    assign bus.value_ready  = value_ready;
    assign bus.matrix_valid = matrix_valid;
    assign bus.matrix_data  = matrix_valid ? bank_data[pres_sel] : '0;
    assign bus.err_short    = err_short_q;
    assign bus.err_long     = err_long_q;

    assign wr_first  = (state == ST_FIRST);
    assign fill_end  = offset + WORD_W;
    assign wr_data   = wr_first ? (bus.value_data >> (8 * HEADER_BYTES)) : bus.value_data;
    assign wr_offset = wr_first ? '0 : offset;

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_n          = state;
        offset_n         = offset;
        drain_err_seen_n = drain_err_seen;
        err_short_n      = 1'b0;
        err_long_n       = 1'b0;
        wr_en            = 1'b0;
        set_full         = 1'b0;
        unique case (state)
            ST_FIRST: if (accept) begin
                wr_en = 1'b1;
                if (FIRST_COMPLETES) begin
                    set_full = 1'b1;
                    state_n  = bus.value_last ? ST_FIRST : ST_DRAIN;
                end else if (bus.value_last) begin
                    err_short_n = 1'b1;
                end else begin
                    state_n  = ST_FILL;
                    offset_n = FIRST_END;
                end
            end
            ST_FILL: if (accept) begin
                wr_en = 1'b1;
                if (fill_end >= MAT_END) begin
                    set_full = 1'b1;
                    offset_n = '0;
                    state_n  = bus.value_last ? ST_FIRST : ST_DRAIN;
                end else if (bus.value_last) begin
                    err_short_n = 1'b1;
                    offset_n    = '0;
                    state_n     = ST_FIRST;
                end else begin
                    offset_n = fill_end;
                end
            end
            ST_DRAIN: if (accept) begin
                err_long_n       = !drain_err_seen;
                drain_err_seen_n = 1'b1;
                if (bus.value_last) begin
                    state_n          = ST_FIRST;
                    drain_err_seen_n = 1'b0;
                end
            end
            default: state_n = ST_FIRST;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_FIRST;
            offset         <= '0;
            fill_sel       <= 1'b0;
            pres_sel       <= 1'b0;
            drain_err_seen <= 1'b0;
            err_short_q    <= 1'b0;
            err_long_q     <= 1'b0;
        end else begin
            state          <= state_n;
            offset         <= offset_n;
            drain_err_seen <= drain_err_seen_n;
            err_short_q    <= err_short_n;
            err_long_q     <= err_long_n;
            if (set_full)  fill_sel <= ~fill_sel;
            if (handshake) pres_sel <= ~pres_sel;
        end
    end

    for (genvar i = 0; i < 2; i++) begin : g_bank
        nukv_matrix_bank #(
            .MEMORY_WIDTH (MEMORY_WIDTH),
            .MATRIX_BITS  (MAT_BITS),
            .OFFSET_W     (OFFSET_W)
        ) u_bank (
            .clk       (clk),
            .rst       (rst),
            .wr_en     (wr_en && (fill_sel == 1'(i))),
            .wr_offset (wr_offset),
            .wr_data   (wr_data),
            .set_full  (set_full && (fill_sel == 1'(i))),
            .clr_full  (handshake && (pres_sel == 1'(i))),
            .data      (bank_data[i]),
            .full      (bank_full[i])
        );
    end
endmodule

// File: tb/tb_nukv_rotation_matrix_assembler.sv
// Randomised bench: a bit-vector concatenation model predicts matrices, errors and back-pressure.
module tb_nukv_rotation_matrix_assembler;
    import nukv_matrix_pkg::*;

    localparam int MW  = DEF_MEMORY_WIDTH;
    localparam int HB  = DEF_HEADER_BYTES;
    localparam int MBA = MB;
    localparam int FB  = FIRST_BITS;
    localparam int MBB = 256;
    localparam int WW  = MBA + MW;

    typedef logic [MBA-1:0] cmp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    nukv_rotation_matrix_assembler_if #(.MEMORY_WIDTH(MW), .MATRIX_BITS(MBA)) bus_a ();
    nukv_rotation_matrix_assembler_if #(.MEMORY_WIDTH(MW), .MATRIX_BITS(MBB)) bus_b ();

    nukv_rotation_matrix_assembler dut_a (.clk(clk), .rst(rst), .bus(bus_a));

    nukv_rotation_matrix_assembler #(.ROW_COUNT(2), .COL_COUNT(2)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input cmp_t got, input cmp_t exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: value phase (0 first word, 1 filling, 2 discarding), bit accumulator, pending queue.
    int             ph = 0;
    bit             long_seen = 1'b0;
    logic [WW-1:0]  acc_v;
    int             acc_bits;
    logic [MBA-1:0] exp_q [$];
    bit             e_short = 1'b0;
    bit             e_long = 1'b0;

    int             ready_pct = 100;
    int             valid_pct = 100;
    bit             saw_not_ready = 1'b0;
    logic [MW-1:0]  sent [$];

    function automatic bit model_ready();
        return (ph == 2) || (exp_q.size() < 2);
    endfunction

    task automatic model_reset();
        ph = 0;
        long_seen = 1'b0;
        exp_q.delete();
        e_short = 1'b0;
        e_long = 1'b0;
    endtask

    task automatic model_update(input bit acc, input bit hs, input logic [MW-1:0] d, input bit last);
        e_short = 1'b0;
        e_long  = 1'b0;
        if (hs) void'(exp_q.pop_front());
        if (acc) begin
            if (ph == 2) begin
                if (!long_seen) e_long = 1'b1;
                long_seen = 1'b1;
                if (last) begin
                    ph = 0;
                    long_seen = 1'b0;
                end
            end else begin
                if (ph == 0) begin
                    acc_v    = WW'(d) >> (8 * HB);
                    acc_bits = FB;
                end else begin
                    acc_v    = acc_v | (WW'(d) << acc_bits);
                    acc_bits = acc_bits + MW;
                end
                if (acc_bits >= MBA) begin
                    exp_q.push_back(acc_v[MBA-1:0]);
                    ph = last ? 0 : 2;
                    long_seen = 1'b0;
                end else if (last) begin
                    e_short = 1'b1;
                    ph = 0;
                end else begin
                    ph = 1;
                end
            end
        end
    endtask

    function automatic logic [MW-1:0] rand_word();
        logic [MW-1:0] w;
        for (int i = 0; i < MW / 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    // One clock: decide acceptance from the model, advance it, then compare after the edge.
    task automatic step(output bit accepted);
        bit hs;
        bus_a.matrix_ready = ($urandom_range(0, 99) < ready_pct);
        if (bus_a.value_ready === 1'b0) saw_not_ready = 1'b1;
        accepted = bus_a.value_valid && model_ready();
        hs = (exp_q.size() > 0) && bus_a.matrix_ready;
        model_update(accepted, hs, bus_a.value_data, bus_a.value_last);
        @(posedge clk);
        #1;
        check("value_ready", cmp_t'(bus_a.value_ready), cmp_t'(model_ready()));
        check("matrix_valid", cmp_t'(bus_a.matrix_valid), cmp_t'(exp_q.size() > 0));
        if (exp_q.size() > 0) check("matrix_data", bus_a.matrix_data, exp_q[0]);
        check("err_short", cmp_t'(bus_a.err_short), cmp_t'(e_short));
        check("err_long", cmp_t'(bus_a.err_long), cmp_t'(e_long));
    endtask

    task automatic idle(input int n);
        bit acc;
        bus_a.value_valid = 1'b0;
        repeat (n) step(acc);
    endtask

    task automatic send_value(input int n, input bit last_at_end);
        logic [MW-1:0] w;
        bit acc;
        int waited;
        sent.delete();
        for (int i = 0; i < n; i++) begin
            w = rand_word();
            sent.push_back(w);
            bus_a.value_data = w;
            bus_a.value_last = last_at_end && (i == n - 1);
            acc = 1'b0;
            waited = 0;
            while (!acc) begin
                bus_a.value_valid = ($urandom_range(0, 99) < valid_pct);
                step(acc);
                waited++;
                if (!acc && waited > 400) begin
                    check("accept_timeout", cmp_t'(1'b0), cmp_t'(1'b1));
                    bus_a.value_valid = 1'b0;
                    return;
                end
            end
        end
        bus_a.value_valid = 1'b0;
        bus_a.value_last  = 1'b0;
    endtask

    task automatic apply_reset(input bit check_b);
        bus_a.value_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_matrix_valid", cmp_t'(bus_a.matrix_valid), cmp_t'(1'b0));
        check("rst_value_ready", cmp_t'(bus_a.value_ready), cmp_t'(1'b1));
        check("rst_err_short", cmp_t'(bus_a.err_short), cmp_t'(1'b0));
        check("rst_err_long", cmp_t'(bus_a.err_long), cmp_t'(1'b0));
        check("rst_matrix_data", bus_a.matrix_data, cmp_t'(1'b0));
        if (check_b) begin
            check("rst_b_matrix_valid", cmp_t'(bus_b.matrix_valid), cmp_t'(1'b0));
            check("rst_b_value_ready", cmp_t'(bus_b.value_ready), cmp_t'(1'b1));
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [MW-1:0]  w1, w2;
        logic [MBA-1:0] exp_m;
        logic [MBB-1:0] exp_b;
        bus_a.value_data   = '0;
        bus_a.value_valid  = 1'b0;
        bus_a.value_last   = 1'b0;
        bus_a.matrix_ready = 1'b0;
        bus_b.value_data   = '0;
        bus_b.value_valid  = 1'b0;
        bus_b.value_last   = 1'b0;
        bus_b.matrix_ready = 1'b1;
        #2;
        apply_reset(1'b1);

        // Two-word value: header stripped, word 2 truncated at the matrix end.
        send_value(2, 1'b1);
        w1 = sent[0];
        w2 = sent[1];
        exp_m = {w2[79:0], w1[511:16]};
        check("two_word_valid", cmp_t'(bus_a.matrix_valid), cmp_t'(1'b1));
        check("two_word_data", bus_a.matrix_data, exp_m);
        check("two_word_no_short", cmp_t'(bus_a.err_short), cmp_t'(1'b0));
        idle(3);

        send_value(1, 1'b1);
        check("short_pulse", cmp_t'(bus_a.err_short), cmp_t'(1'b1));
        send_value(2, 1'b1);
        idle(3);

        send_value(3, 1'b1);
        check("long_pulse", cmp_t'(bus_a.err_long), cmp_t'(1'b1));
        idle(3);

        // Back-pressure: two buffered matrices stall the third value until the first handshake.
        ready_pct = 0;
        saw_not_ready = 1'b0;
        fork
            begin
                send_value(2, 1'b1);
                send_value(2, 1'b1);
                send_value(2, 1'b1);
            end
            begin
                repeat (30) @(posedge clk);
                ready_pct = 100;
            end
        join
        check("backpressure_seen", cmp_t'(saw_not_ready), cmp_t'(1'b1));
        idle(6);

        // Reset with one matrix presented and another value half-filled.
        ready_pct = 0;
        send_value(2, 1'b1);
        send_value(1, 1'b0);
        apply_reset(1'b0);
        ready_pct = 100;
        send_value(2, 1'b1);
        idle(3);

        for (int k = 0; k < 300; k++) begin
            ready_pct = $urandom_range(20, 100);
            valid_pct = $urandom_range(50, 100);
            if ($urandom_range(0, 19) == 0) begin
                send_value($urandom_range(1, 2), 1'b0);
                apply_reset(1'b0);
            end else begin
                send_value($urandom_range(1, 4), 1'b1);
            end
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        ready_pct = 100;
        idle(8);

        // Small matrix: a single word completes it.
        w1 = rand_word();
        exp_b = w1[271:16];
        check("b_ready", cmp_t'(bus_b.value_ready), cmp_t'(1'b1));
        bus_b.value_data  = w1;
        bus_b.value_valid = 1'b1;
        bus_b.value_last  = 1'b1;
        @(posedge clk);
        #1;
        bus_b.value_valid = 1'b0;
        bus_b.value_last  = 1'b0;
        check("b_valid", cmp_t'(bus_b.matrix_valid), cmp_t'(1'b1));
        check("b_data", cmp_t'(bus_b.matrix_data), cmp_t'(exp_b));
        check("b_no_short", cmp_t'(bus_b.err_short), cmp_t'(1'b0));
        check("b_no_long", cmp_t'(bus_b.err_long), cmp_t'(1'b0));
        @(posedge clk);
        #1;
        check("b_consumed", cmp_t'(bus_b.matrix_valid), cmp_t'(1'b0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
